// File: rtl/pe_pkg.sv
// Shared widths, control bundle and saturating-add helper for the processing-element family.
package pe_pkg;

  localparam int PE_DATA_W   = 8;
  localparam int PE_WEIGHT_W = 8;
  localparam int PE_SUM_W    = 16;

  typedef struct packed {
    logic active;
    logic wwrite;
    logic wswap;
  } pe_ctrl_t;

  // Returns {sum, flag}; flag marks signed overflow whether or not the result was clamped.
  function automatic logic [PE_SUM_W:0] sat_add(
    input logic [PE_SUM_W-1:0] a,
    input logic [PE_SUM_W-1:0] b,
    input logic                saturate
  );
    logic [PE_SUM_W:0]   wide;
    logic                ovf;
    logic [PE_SUM_W-1:0] s;
    wide = {a[PE_SUM_W-1], a} + {b[PE_SUM_W-1], b};
    ovf  = wide[PE_SUM_W] ^ wide[PE_SUM_W-1];
    s    = wide[PE_SUM_W-1:0];
    if (saturate && ovf)
      s = wide[PE_SUM_W] ? {1'b1, {(PE_SUM_W-1){1'b0}}} : {1'b0, {(PE_SUM_W-1){1'b1}}};
    return {s, ovf};
  endfunction

endpackage

// File: rtl/pe_sat_adder.sv
// Combinational signed add in SUM_W+1 bits with optional clamp and overflow detect.
module pe_sat_adder #(
  parameter int SUM_W    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic [SUM_W-1:0] a,
  input  logic [SUM_W-1:0] b,
  output logic [SUM_W-1:0] sum,
  output logic             flag
);

  logic [SUM_W:0] wide;
  logic           ovf;

  // The two top bits of the widened sum disagree exactly when the SUM_W result overflowed.
  assign wide = {a[SUM_W-1], a} + {b[SUM_W-1], b};
  assign ovf  = wide[SUM_W] ^ wide[SUM_W-1];
  assign flag = ovf;

  always_comb begin
    sum = wide[SUM_W-1:0];
    if (SATURATE && ovf)
      sum = wide[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
  end

endmodule

// File: rtl/pe_dbuf.sv
// Weight-stationary MAC cell with a double-buffered weight (shadow loads while working computes).
module pe_dbuf
  import pe_pkg::*;
#(
  parameter int DATA_W   = PE_DATA_W,
  parameter int WEIGHT_W = PE_WEIGHT_W,
  parameter int SUM_W    = PE_SUM_W,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                active,
  input  logic [DATA_W-1:0]   datain,
  input  logic [SUM_W-1:0]    sumin,
  input  logic [WEIGHT_W-1:0] win,
  input  logic                wwrite,
  input  logic                wswap,
  output logic [DATA_W-1:0]   dataout,
  output logic [SUM_W-1:0]    maccout,
  output logic                satout,
  output logic [WEIGHT_W-1:0] wout,
  output logic                wwriteout,
  output logic                wswapout,
  output logic                activeout
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  if (SUM_W < PROD_W) begin : g_width_check
    $error("pe_dbuf: SUM_W must be at least DATA_W+WEIGHT_W");
  end

  logic [WEIGHT_W-1:0]      shadow_reg;
  logic [WEIGHT_W-1:0]      working_reg;
  logic [WEIGHT_W-1:0]      wout_reg;
  logic [DATA_W-1:0]        dataout_reg;
  logic [SUM_W-1:0]         maccout_reg;
  logic                     satout_reg;
  pe_ctrl_t                 ctrl_reg;

  logic signed [PROD_W-1:0] product;
  logic [SUM_W-1:0]         sum_next;
  logic                     flag_next;

  assign product = PROD_W'($signed(datain)) * PROD_W'($signed(working_reg));

  pe_sat_adder #(
    .SUM_W    (SUM_W),
    .SATURATE (SATURATE)
  ) u_adder (
    .a    (sumin),
    .b    (SUM_W'(product)),
    .sum  (sum_next),
    .flag (flag_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_reg  <= '0;
      working_reg <= '0;
      wout_reg    <= '0;
      dataout_reg <= '0;
      maccout_reg <= '0;
      satout_reg  <= 1'b0;
      ctrl_reg    <= '0;
    end else begin
      ctrl_reg <= '{active: active, wwrite: wwrite, wswap: wswap};
      if (wwrite)
        shadow_reg <= win;
      // Swap reads the pre-edge shadow, so a same-edge shift never leaks into working.
      if (wswap)
        working_reg <= shadow_reg;
      // The trailing cycle keeps forwarding so the bottom of the column gets its weight.
      wout_reg <= (wwrite || ctrl_reg.wwrite) ? shadow_reg : '0;
      if (active) begin
        dataout_reg <= datain;
        maccout_reg <= sum_next;
        satout_reg  <= flag_next;
      end else begin
        satout_reg  <= 1'b0;
      end
    end
  end

  assign dataout   = dataout_reg;
  assign maccout   = maccout_reg;
  assign satout    = satout_reg;
  assign wout      = wout_reg;
  assign wwriteout = ctrl_reg.wwrite;
  assign wswapout  = ctrl_reg.wswap;
  assign activeout = ctrl_reg.active;

endmodule

// File: tb/tb_pe_dbuf.sv
// Directed bench for pe_dbuf: one saturating and one wrapping instance share the same stimulus.
module tb_pe_dbuf;

  logic        clock = 1'b0;
  logic        reset;
  logic        active;
  logic [7:0]  datain;
  logic [15:0] sumin;
  logic [7:0]  win;
  logic        wwrite;
  logic        wswap;

  logic [7:0]  dataout,  dataout_w;
  logic [15:0] maccout,  maccout_w;
  logic        satout,   satout_w;
  logic [7:0]  wout,     wout_w;
  logic        wwriteout, wwriteout_w;
  logic        wswapout,  wswapout_w;
  logic        activeout, activeout_w;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pe_dbuf #(.DATA_W(8), .WEIGHT_W(8), .SUM_W(16), .SATURATE(1'b1)) dut_sat (
    .clock(clock), .reset(reset), .active(active), .datain(datain), .sumin(sumin),
    .win(win), .wwrite(wwrite), .wswap(wswap), .dataout(dataout), .maccout(maccout),
    .satout(satout), .wout(wout), .wwriteout(wwriteout), .wswapout(wswapout),
    .activeout(activeout)
  );

  pe_dbuf #(.DATA_W(8), .WEIGHT_W(8), .SUM_W(16), .SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .active(active), .datain(datain), .sumin(sumin),
    .win(win), .wwrite(wwrite), .wswap(wswap), .dataout(dataout_w), .maccout(maccout_w),
    .satout(satout_w), .wout(wout_w), .wwriteout(wwriteout_w), .wswapout(wswapout_w),
    .activeout(activeout_w)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic a, input int d, input int s, input int w,
                       input logic ww, input logic sw);
    active = a;
    datain = 8'(d);
    sumin  = 16'(s);
    win    = 8'(w);
    wwrite = ww;
    wswap  = sw;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if ({dataout, maccout, satout, wout, wwriteout, wswapout, activeout} !== 37'd0) begin
      failures++;
      $display("FAIL reset_state outputs got %h want 0",
               {dataout, maccout, satout, wout, wwriteout, wswapout, activeout});
    end
    reset = 1'b0;
    $display("reset: outputs=%h", {dataout, maccout, satout, wout});
  endtask

  task automatic test_reset_mid_load();
    drive(1'b0, 0, 0, 5, 1'b1, 1'b0);
    step();
    checks++;
    if (wout !== 8'd0) begin
      failures++; $display("FAIL load1_wout got %0d want 0", wout);
    end
    step();
    checks++;
    if (wout !== 8'd5 || wwriteout !== 1'b1) begin
      failures++; $display("FAIL load2_wout got %0d/%b want 5/1", wout, wwriteout);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({dataout, maccout, satout, wout, wwriteout, wswapout, activeout} !== 37'd0) begin
      failures++;
      $display("FAIL async_reset outputs got %h want 0",
               {dataout, maccout, satout, wout, wwriteout, wswapout, activeout});
    end
    #1 reset = 1'b0;
    drive(1'b1, 3, 100, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 100 || dataout !== 8'd3 || satout !== 1'b0 || wout !== 8'd0) begin
      failures++;
      $display("FAIL post_reset_mac got macc=%0d data=%0d sat=%b wout=%0d want 100/3/0/0",
               $signed(maccout), dataout, satout, wout);
    end
    $display("reset_mid_load: macc=%0d", $signed(maccout));
  endtask

  task automatic test_swap_no_bubble();
    drive(1'b0, 0, 0, 2, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step();
    checks++;
    if (wout !== 8'd2 || wswapout !== 1'b1) begin
      failures++; $display("FAIL trailing_wout got %0d/%b want 2/1", wout, wswapout);
    end
    drive(1'b1, 10, 1, 4, 1'b1, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 21 || dataout !== 8'd10) begin
      failures++; $display("FAIL load_cycle_macc got %0d/%0d want 21/10", $signed(maccout), dataout);
    end
    drive(1'b1, 10, 1, 0, 1'b0, 1'b1);
    step();
    checks++;
    if ($signed(maccout) !== 21) begin
      failures++; $display("FAIL swap_cycle_macc got %0d want 21", $signed(maccout));
    end
    drive(1'b1, 10, 1, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 41 || satout !== 1'b0) begin
      failures++; $display("FAIL after_swap_macc got %0d/%b want 41/0", $signed(maccout), satout);
    end
    $display("swap_no_bubble: macc=%0d", $signed(maccout));
  endtask

  task automatic test_simultaneous();
    drive(1'b0, 0, 0, 7, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, -3, 1'b1, 1'b1);
    step();
    checks++;
    if (wout !== 8'd7) begin
      failures++; $display("FAIL simul_wout got %0d want 7", wout);
    end
    drive(1'b1, 2, 0, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 14 || $signed(wout) !== -3) begin
      failures++;
      $display("FAIL simul_working got macc=%0d wout=%0d want 14/-3", $signed(maccout), $signed(wout));
    end
    drive(1'b1, 2, 0, 0, 1'b0, 1'b1);
    step();
    checks++;
    if ($signed(maccout) !== 14 || wout !== 8'd0) begin
      failures++;
      $display("FAIL simul_idle got macc=%0d wout=%0d want 14/0", $signed(maccout), wout);
    end
    drive(1'b1, 2, 0, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== -6) begin
      failures++; $display("FAIL simul_shadow got %0d want -6", $signed(maccout));
    end
    $display("simultaneous: macc=%0d", $signed(maccout));
  endtask

  task automatic test_saturation();
    drive(1'b0, 0, 0, 127, 1'b1, 1'b0);
    step();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    step();
    drive(1'b1, 127, 32000, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 32767 || satout !== 1'b1) begin
      failures++; $display("FAIL sat_pos got %0d/%b want 32767/1", $signed(maccout), satout);
    end
    checks++;
    if ($signed(maccout_w) !== -17407 || satout_w !== 1'b1) begin
      failures++; $display("FAIL wrap_pos got %0d/%b want -17407/1", $signed(maccout_w), satout_w);
    end
    drive(1'b1, -128, -32000, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== -32768 || satout !== 1'b1) begin
      failures++; $display("FAIL sat_neg got %0d/%b want -32768/1", $signed(maccout), satout);
    end
    checks++;
    if ($signed(maccout_w) !== 17280 || satout_w !== 1'b1) begin
      failures++; $display("FAIL wrap_neg got %0d/%b want 17280/1", $signed(maccout_w), satout_w);
    end
    drive(1'b1, 1, 5, 0, 1'b0, 1'b0);
    step();
    checks++;
    if ($signed(maccout) !== 132 || satout !== 1'b0 || $signed(maccout_w) !== 132 || satout_w !== 1'b0) begin
      failures++;
      $display("FAIL no_overflow got %0d/%b %0d/%b want 132/0 132/0",
               $signed(maccout), satout, $signed(maccout_w), satout_w);
    end
    $display("saturation: sat=%0d wrap=%0d", $signed(maccout), $signed(maccout_w));
  endtask

  task automatic test_stall();
    logic [7:0] exp_wout [3] = '{8'd127, 8'd9, 8'd10};
    int         wins     [3] = '{9, 10, 11};
    checks++;
    if (activeout !== 1'b1) begin
      failures++; $display("FAIL pre_stall_activeout got %b want 1", activeout);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 0, 0, wins[i], 1'b1, 1'b0);
      datain = (i == 1) ? 8'hxx : 8'(i * 37 + 1);
      sumin  = (i == 2) ? 16'hxxxx : 16'(i * 1000 + 7);
      step();
      checks++;
      if (dataout !== 8'd1 || $signed(maccout) !== 132 || satout !== 1'b0 || activeout !== 1'b0
          || wout !== exp_wout[i]) begin
        failures++;
        $display("FAIL stall_%0d got data=%h macc=%h sat=%b act=%b wout=%0d want 01/0084/0/0/%0d",
                 i, dataout, maccout, satout, activeout, wout, exp_wout[i]);
      end
    end
    checks++;
    if (maccout_w !== 16'd132 || satout_w !== 1'b0) begin
      failures++; $display("FAIL stall_wrap got %h/%b want 0084/0", maccout_w, satout_w);
    end
    $display("stall: data=%0d macc=%0d wout=%0d", dataout, $signed(maccout), wout);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_mid_load();
    test_swap_no_bubble();
    test_simultaneous();
    test_saturation();
    test_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_dbuf.md
Name: pe_dbuf

Overview:
- Parametrised successor to the systolic-array processing element.
- Weight-stationary MAC cell with a double-buffered weight: a shadow register loads through the column shift chain while the working register keeps computing. A swap strobe then moves the new weight into service with zero bubble.
- Configurable operand and partial-sum widths, with optional saturating accumulation and an overflow flag.
- Tiles in a 2-D grid: data flows right, weights and control flow down, partial sums flow down.

Parameters:
- DATA_W, 8, signed activation width.
- WEIGHT_W, 8, signed weight width.
- SUM_W, 16, signed partial-sum width; SUM_W >= DATA_W+WEIGHT_W is required (elaboration error otherwise).
- SATURATE, 1, 1 = clamp the sum to the signed SUM_W range; 0 = two's-complement wrap.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- active  in  1  MAC enable; low = stall, holding the data and sum outputs.
- datain  in  DATA_W  signed activation from the left neighbour.
- sumin  in  SUM_W  signed partial sum from the upper neighbour.
- win  in  WEIGHT_W  signed weight from the upper neighbour's shift chain.
- wwrite  in  1  shift-load strobe for the shadow weight.
- wswap  in  1  copy shadow to working weight.
- dataout  out  DATA_W  registered datain, passed right.
- maccout  out  SUM_W  registered sumin + datain*weight.
- satout  out  1  high for one cycle when maccout was clamped (or wrapped when SATURATE=0).
- wout  out  WEIGHT_W  previous shadow weight, passed down.
- wwriteout  out  1  registered wwrite.
- wswapout  out  1  registered wswap.
- activeout  out  1  registered active.

Behaviour:
- Reset (asynchronous, any time, including mid-load or mid-compute): every output register, the shadow weight and the working weight go to 0. The first cycle after reset deassertion behaves as an ordinary idle cycle.
- All outputs are registered; latency from any input to its output is 1 cycle.
- Control passthrough: activeout, wwriteout and wswapout follow active, wwrite and wswap with 1-cycle delay, unconditionally (not gated by active).
- Weight shift (wwrite=1): shadow <= win and wout <= old shadow. An N-deep column therefore loads in N cycles.
- Weight idle (wwrite=0 and wwriteout=0): shadow holds and wout <= 0. The old 8'hAA idle filler is dropped.
- Trailing cycle (wwrite=0, wwriteout=1): wout still forwards the shadow, so the bottom PE receives its weight.
- Swap (wswap=1): working <= shadow on that edge.
- Simultaneous wwrite and wswap: working takes the OLD shadow, and shadow takes win in the same edge.
- Swap relative to computation:
  - A MAC in the same cycle as a swap uses the OLD working weight.
  - The new weight applies from the next cycle.
  - wswap is independent of active; swapping during a stall is legal.
- MAC (active=1):
  - product = datain*working, full DATA_W+WEIGHT_W signed, sign-extended.
  - sum = sumin + product, computed in SUM_W+1 bits.
  - SATURATE=1: values above 2^(SUM_W-1)-1 clamp to max and values below -2^(SUM_W-1) clamp to min; satout <= 1 if clamped, else 0.
  - SATURATE=0: keep the low SUM_W bits; satout <= 1 if signed overflow occurred.
  - dataout <= datain.
- Stall (active=0): dataout and maccout hold, satout <= 0, and the weight path still operates.
- Unknown (X) on datain or sumin while active=0 must not propagate to the outputs.

Decomposition:
- Package pe_pkg holds:
  - default width constants (PE_DATA_W, PE_WEIGHT_W, PE_SUM_W);
  - a packed struct for the control bundle {active, wwrite, wswap};
  - a function sat_add(a, b, saturate) returning {sum, flag}.
- One natural sub-module: pe_sat_adder, a combinational widened add plus clamp/overflow detect, parametrised on SUM_W. It is reused later by accumulator columns.
- The multiplier is inferred (mapped to DSP) inside pe_dbuf.

Test Plan:
1. Reset mid-load: wwrite=1 with win=5 for 2 cycles, then assert reset asynchronously between edges -> all outputs 0 immediately; after release, a MAC with datain=3 gives maccout=sumin.
2. Shift/swap, no bubble:
   - Load shadow=4 while working=2, active=1, datain=10, sumin=1 -> maccout=21 for each cycle up to and including the swap cycle.
   - The cycle after the swap -> maccout=41.
3. Simultaneous wwrite and wswap: shadow=7, win=-3 -> working=7, shadow=-3, and wout=7 on the next cycle.
4. Saturation, SATURATE=1, defaults:
   - datain=127, weight=127, sumin=32000 -> maccout=32767, satout=1.
   - datain=-128, weight=127, sumin=-32000 -> maccout=-32768, satout=1.
5. Wrap, SATURATE=0, same positive case -> maccout=(32000+16129) mod 2^16 as signed = -17407, satout=1.
6. Stall: active=0 for 3 cycles while datain/sumin toggle (including X) -> dataout/maccout unchanged, satout=0, activeout=0 delayed by 1 cycle; the weight shift continues during the stall.
